// File: rtl/ccc_lock_rst_seq_pkg.sv
// Shared types and helpers for the lock-qualified reset/clock-enable sequencer.
package ccc_seq_pkg;

  localparam logic [1:0] STATE_WAIT_LOCK = 2'd0;
  localparam logic [1:0] STATE_FILTER    = 2'd1;
  localparam logic [1:0] STATE_SEQ       = 2'd2;
  localparam logic [1:0] STATE_RUN       = 2'd3;

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = STATE_WAIT_LOCK,
    ST_FILTER    = STATE_FILTER,
    ST_SEQ       = STATE_SEQ,
    ST_RUN       = STATE_RUN
  } seq_state_e;

  // Width needed to hold 0..value-1, never less than one bit.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) w = i + 1;
    end
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/ccc_lock_rst_seq_if.sv
// Control/status bundle between the CCC sequencer and its user.
interface ccc_lock_rst_seq_if #(
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned CNT_W  = 8
);
  logic              LOCK;
  logic              FORCE_RST;
  logic              CLR_CNT;
  logic [NUM_CH-1:0] GL_EN;
  logic [NUM_CH-1:0] CH_RST_N;
  logic              ALL_READY;
  logic [1:0]        STATE;
  logic              LOCK_LOST;
  logic [CNT_W-1:0]  LOSS_CNT;

  modport master (
    output LOCK, FORCE_RST, CLR_CNT,
    input  GL_EN, CH_RST_N, ALL_READY, STATE, LOCK_LOST, LOSS_CNT
  );

  modport slave (
    input  LOCK, FORCE_RST, CLR_CNT,
    output GL_EN, CH_RST_N, ALL_READY, STATE, LOCK_LOST, LOSS_CNT
  );
endinterface

// File: rtl/ccc_lock_rst_seq_sync.sv
// Flop-chain synchroniser with async active-low clear; used for LOCK and reset release.
module ccc_lock_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain <= '0;
    else        chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];
endmodule

// File: rtl/ccc_lock_rst_seq.sv
// Lock-qualified, staggered per-channel clock-enable and reset release for CCC outputs.
module ccc_lock_rst_seq
  import ccc_seq_pkg::*;
#(
  parameter int unsigned NUM_CH      = 3,
  parameter int unsigned LOCK_FILTER = 1024,
  parameter int unsigned STAGGER     = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 8
) (
  input logic              CLK,
  input logic              RESET_N,
  ccc_lock_rst_seq_if.slave bus
);
  localparam int unsigned FW = clog2(LOCK_FILTER);
  localparam int unsigned TW = clog2(STAGGER);
  localparam int unsigned IW = clog2(NUM_CH);
  localparam logic [FW-1:0] FILT_LAST = FW'(LOCK_FILTER - 1);
  localparam logic [TW-1:0] TMR_LAST  = TW'(STAGGER - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_CH - 1);

  logic rst_int;
  logic lock_s;

  ccc_lock_sync #(.STAGES(2)) u_rst_sync (
    .clk(CLK), .rst_n(RESET_N), .d(1'b1), .q(rst_int)
  );

  ccc_lock_sync #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk(CLK), .rst_n(rst_int), .d(bus.LOCK), .q(lock_s)
  );

  seq_state_e        state_q, state_d;
  logic [FW-1:0]     filt_q, filt_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [NUM_CH-1:0] gl_q, gl_d;
  logic [NUM_CH-1:0] rstn_q, rstn_d;
  logic              rdy_q, rdy_d;
  logic              lost_q, lost_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              abort;
  logic              loss_inc;

  always_ff @(posedge CLK or negedge rst_int) begin
    if (!rst_int) begin
      state_q <= ST_WAIT_LOCK;
      filt_q  <= '0;
      tmr_q   <= '0;
      idx_q   <= '0;
      gl_q    <= '0;
      rstn_q  <= '0;
      rdy_q   <= 1'b0;
      lost_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      filt_q  <= filt_d;
      tmr_q   <= tmr_d;
      idx_q   <= idx_d;
      gl_q    <= gl_d;
      rstn_q  <= rstn_d;
      rdy_q   <= rdy_d;
      lost_q  <= lost_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    filt_d   = filt_q;
    tmr_d    = tmr_q;
    idx_d    = idx_q;
    gl_d     = gl_q;
    rstn_d   = rstn_q;
    rdy_d    = rdy_q;
    loss_inc = 1'b0;
    abort    = !lock_s || bus.FORCE_RST;

    // Abort outranks progress everywhere except WAIT_LOCK, which handles it by staying.
    if (abort && state_q != ST_WAIT_LOCK) begin
      state_d  = ST_WAIT_LOCK;
      filt_d   = '0;
      tmr_d    = '0;
      idx_d    = '0;
      gl_d     = '0;
      rstn_d   = '0;
      rdy_d    = 1'b0;
      loss_inc = !lock_s && (state_q == ST_SEQ || state_q == ST_RUN);
    end else begin
      unique case (state_q)
        ST_WAIT_LOCK: begin
          if (!abort) begin
            state_d = ST_FILTER;
            filt_d  = '0;
          end
        end
        ST_FILTER: begin
          if (filt_q == FILT_LAST) begin
            state_d = ST_SEQ;
            idx_d   = '0;
            tmr_d   = '0;
            gl_d[0] = 1'b1;
          end else begin
            filt_d = filt_q + 1'b1;
          end
        end
        ST_SEQ: begin
          if (tmr_q == TMR_LAST) begin
            tmr_d         = '0;
            rstn_d[idx_q] = 1'b1;
            if (idx_q == IDX_LAST) begin
              state_d = ST_RUN;
              rdy_d   = 1'b1;
            end else begin
              idx_d       = idx_q + 1'b1;
              gl_d[idx_d] = 1'b1;
            end
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
        ST_RUN: begin
          rdy_d = 1'b1;
        end
      endcase
    end

    // Clear wins over an increment for the count; a new loss wins over clear for the flag.
    cnt_d = cnt_q;
    if (bus.CLR_CNT)                 cnt_d = '0;
    else if (loss_inc && cnt_q != '1) cnt_d = cnt_q + 1'b1;

    lost_d = lost_q;
    if (loss_inc)         lost_d = 1'b1;
    else if (bus.CLR_CNT) lost_d = 1'b0;
  end

  assign bus.GL_EN     = gl_q;
  assign bus.CH_RST_N  = rstn_q;
  assign bus.ALL_READY = rdy_q;
  assign bus.STATE     = state_q;
  assign bus.LOCK_LOST = lost_q;
  assign bus.LOSS_CNT  = cnt_q;
endmodule

// File: tb/tb_ccc_lock_rst_seq.sv
// Directed bench for ccc_lock_rst_seq: NUM_CH=3, LOCK_FILTER=8, STAGGER=4, SYNC_STAGES=2, CNT_W=2.
module tb_ccc_lock_rst_seq;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  ccc_lock_rst_seq_if #(.NUM_CH(3), .CNT_W(2)) bus ();

  ccc_lock_rst_seq #(
    .NUM_CH(3), .LOCK_FILTER(8), .STAGGER(4), .SYNC_STAGES(2), .CNT_W(2)
  ) dut (
    .CLK(clk), .RESET_N(rst_n), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered just after the edge that moved the FSM into FILTER (edge F).
  task automatic bringup_from_filter(input string tag);
    tick(7);
    chk({tag, "_filt_state"}, 32'(bus.STATE), 32'd1);
    chk({tag, "_filt_gl"}, 32'(bus.GL_EN), 32'd0);
    tick(1);
    chk({tag, "_seq_state"}, 32'(bus.STATE), 32'd2);
    chk({tag, "_seq_gl"}, 32'(bus.GL_EN), 32'b001);
    chk({tag, "_seq_rst"}, 32'(bus.CH_RST_N), 32'b000);
    tick(4);
    chk({tag, "_ch0_rst"}, 32'(bus.CH_RST_N), 32'b001);
    chk({tag, "_ch0_gl"}, 32'(bus.GL_EN), 32'b011);
    tick(4);
    chk({tag, "_ch1_rst"}, 32'(bus.CH_RST_N), 32'b011);
    chk({tag, "_ch1_gl"}, 32'(bus.GL_EN), 32'b111);
    tick(3);
    chk({tag, "_pre_ready"}, 32'(bus.ALL_READY), 32'd0);
    tick(1);
    chk({tag, "_ch2_rst"}, 32'(bus.CH_RST_N), 32'b111);
    chk({tag, "_ready"}, 32'(bus.ALL_READY), 32'd1);
    chk({tag, "_run_state"}, 32'(bus.STATE), 32'd3);
  endtask

  // LOCK was raised just before the next edge (edge 1).
  task automatic bringup(input string tag);
    tick(2);
    chk({tag, "_e2_state"}, 32'(bus.STATE), 32'd0);
    tick(1);
    chk({tag, "_e3_state"}, 32'(bus.STATE), 32'd1);
    bringup_from_filter(tag);
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    rst_n         = 1'b0;
    bus.LOCK      = 1'b0;
    bus.FORCE_RST = 1'b0;
    bus.CLR_CNT   = 1'b0;

    tick(3);
    chk("rst_gl", 32'(bus.GL_EN), 32'd0);
    chk("rst_ch", 32'(bus.CH_RST_N), 32'd0);
    chk("rst_ready", 32'(bus.ALL_READY), 32'd0);
    chk("rst_state", 32'(bus.STATE), 32'd0);
    chk("rst_lost", 32'(bus.LOCK_LOST), 32'd0);
    chk("rst_cnt", 32'(bus.LOSS_CNT), 32'd0);
    rst_n = 1'b1;
    tick(4);
    chk("idle_state", 32'(bus.STATE), 32'd0);

    // Nominal bring-up
    bus.LOCK = 1'b1;
    bringup("nom");

    // Loss in RUN: two edges through the synchroniser, abort on the third
    bus.LOCK = 1'b0;
    tick(2);
    chk("loss_still_run", 32'(bus.STATE), 32'd3);
    tick(1);
    chk("loss_ch", 32'(bus.CH_RST_N), 32'd0);
    chk("loss_gl", 32'(bus.GL_EN), 32'd0);
    chk("loss_state", 32'(bus.STATE), 32'd0);
    chk("loss_ready", 32'(bus.ALL_READY), 32'd0);
    chk("loss_lost", 32'(bus.LOCK_LOST), 32'd1);
    chk("loss_cnt", 32'(bus.LOSS_CNT), 32'd1);

    // Filter restart: LOCK low for edges 6..8
    bus.LOCK = 1'b1;
    tick(5);
    bus.LOCK = 1'b0;
    tick(2);
    chk("frst_e7_state", 32'(bus.STATE), 32'd1);
    tick(1);
    chk("frst_e8_state", 32'(bus.STATE), 32'd0);
    chk("frst_cnt", 32'(bus.LOSS_CNT), 32'd1);
    bus.LOCK = 1'b1;
    bringup("frst");

    // One-cycle soft re-sequence in RUN
    bus.FORCE_RST = 1'b1;
    tick(1);
    bus.FORCE_RST = 1'b0;
    chk("force_ch", 32'(bus.CH_RST_N), 32'd0);
    chk("force_gl", 32'(bus.GL_EN), 32'd0);
    chk("force_state", 32'(bus.STATE), 32'd0);
    chk("force_cnt", 32'(bus.LOSS_CNT), 32'd1);
    tick(1);
    chk("force_filter", 32'(bus.STATE), 32'd1);
    bringup_from_filter("force");

    // Held FORCE_RST keeps WAIT_LOCK
    bus.FORCE_RST = 1'b1;
    tick(6);
    chk("hold_state", 32'(bus.STATE), 32'd0);
    chk("hold_cnt", 32'(bus.LOSS_CNT), 32'd1);
    bus.FORCE_RST = 1'b0;
    bus.LOCK      = 1'b0;
    tick(3);

    // Losses 2..5 during SEQ; 2-bit count saturates at 3
    for (int n = 2; n <= 5; n++) begin
      bus.LOCK = 1'b1;
      tick(11);
      chk("sat_in_seq", 32'(bus.STATE), 32'd2);
      bus.LOCK = 1'b0;
      tick(3);
      chk("sat_state", 32'(bus.STATE), 32'd0);
      chk("sat_cnt", 32'(bus.LOSS_CNT), (n > 3) ? 32'd3 : 32'(n));
    end

    // 6th loss with CLR_CNT on the same edge
    bus.LOCK = 1'b1;
    tick(11);
    bus.LOCK = 1'b0;
    tick(2);
    bus.CLR_CNT = 1'b1;
    tick(1);
    bus.CLR_CNT = 1'b0;
    chk("clr_inc_cnt", 32'(bus.LOSS_CNT), 32'd0);
    chk("clr_inc_lost", 32'(bus.LOCK_LOST), 32'd1);
    bus.CLR_CNT = 1'b1;
    tick(1);
    bus.CLR_CNT = 1'b0;
    chk("clr_lost", 32'(bus.LOCK_LOST), 32'd0);

    // Async reset mid-SEQ once channel 0 is released
    bus.LOCK = 1'b1;
    tick(15);
    chk("ar_pre_ch", 32'(bus.CH_RST_N), 32'b001);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_ch", 32'(bus.CH_RST_N), 32'd0);
    chk("ar_gl", 32'(bus.GL_EN), 32'd0);
    chk("ar_state", 32'(bus.STATE), 32'd0);
    chk("ar_ready", 32'(bus.ALL_READY), 32'd0);
    tick(2);
    rst_n = 1'b1;
    // Two edges for reset release, two more for LOCK, FILTER on the fifth
    tick(4);
    chk("ar_r4_state", 32'(bus.STATE), 32'd0);
    tick(1);
    chk("ar_r5_state", 32'(bus.STATE), 32'd1);
    bringup_from_filter("ar");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
